class_hvec_search: RTL and testbench
====================================

# class_hvec_search

Associative-memory search engine that reads the class-hypervector generator frame by frame and returns the class closest to a query hypervector by Hamming distance. It is the reader side of the `class_hvec_gen` frame interface. It drives `frame_id`/`frame_index` and consumes `class_vec_out` combinationally in the same cycle. It sits after the encoder: the encoded query is streamed in as `NUM_FRAMES` words of `DI_PARALLEL_W_BITS` bits, and the predicted label is handed to the output stage through a valid/ready handshake.

## Interface
- DI_PARALLEL_W_BITS, 64, width of one hypervector frame
- NUM_CLASSES, 8, number of stored classes; `frame_id` width = $clog2(NUM_CLASSES)
- NUM_FRAMES, 3, frames per hypervector; `frame_index` width = 2 (never driven to 3)
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- q_valid  in  1  query frame valid
- q_ready  out  1  engine accepts a query frame
- q_data  in  DI_PARALLEL_W_BITS  query frame, frame 0 first
- frame_id  out  3  class select to generator
- frame_index  out  2  frame select to generator
- class_vec_in  in  DI_PARALLEL_W_BITS  generator output, combinational from frame_id/frame_index
- res_valid  out  1  result valid
- res_ready  in  1  result consumed
- res_class  out  3  index of the nearest class
- res_dist  out  DW  Hamming distance of the winner; DW = $clog2(NUM_FRAMES*DI_PARALLEL_W_BITS+1) = 8
- busy  out  1  high in SEARCH

## Operation
- FSM states: LOAD, SEARCH, DONE. Reset state: LOAD.
- LOAD:
  - q_ready=1.
  - Each q_valid&q_ready stores q_data into query buffer slot `ld_cnt`, then increments `ld_cnt`.
  - Handshake on slot NUM_FRAMES-1 clears `ld_cnt`, `cls_cnt`, `frm_cnt`, `acc`; sets best_dist to all-ones and best_class to 0; goes to SEARCH.
- SEARCH:
  - q_ready=0; frame_id=`cls_cnt`; frame_index=`frm_cnt`.
  - Each cycle computes `pc` = popcount(query[frm_cnt] ^ class_vec_in).
  - When frm_cnt < NUM_FRAMES-1: acc += pc and frm_cnt increments.
  - When frm_cnt = NUM_FRAMES-1:
    - total = acc + pc.
    - If total < best_dist (strict), best_dist/best_class take total/cls_cnt. Ties keep the lower class index.
    - acc and frm_cnt clear; cls_cnt increments.
  - On the last frame of class NUM_CLASSES-1, res_class/res_dist register the final winner (including this cycle's compare) and the FSM goes to DONE.
- DONE:
  - res_valid=1; res_class/res_dist are held stable until res_ready.
  - On res_valid&res_ready the FSM goes to LOAD.
- Outside SEARCH: frame_id=0, frame_index=0.
- Arithmetic:
  - pc is 7 bits; acc and total are DW bits and cannot overflow (max 192).
  - best_dist is DW bits; its initial value 255 guarantees class 0 always wins the first compare.
- Query frames presented in SEARCH or DONE are not accepted (q_ready=0).
- Reset mid-operation returns to LOAD immediately and asynchronously. A partial query load or search is discarded.

## Timing
- Reset values: q_ready=1, res_valid=0, res_class=0, res_dist=0, frame_id=0, frame_index=0, busy=0.
- Query load: NUM_FRAMES handshakes, back-to-back allowed, gaps allowed.
- Search: exactly NUM_CLASSES*NUM_FRAMES cycles (24), with no stalls.
- Latency:
  - res_valid rises after the 24th rising edge following the edge that accepted the last query frame.
  - res_class/res_dist become valid in that same cycle.
- Throughput: a new query may start loading the cycle after the res handshake. Minimum period is 3+24+1 = 28 cycles.
- The generator path is purely combinational within one cycle: frame_id/frame_index registered → ROM → XOR → popcount → adder → compare → register.

## Structure
- Package `hdc_search_pkg`:
  - `search_state_t` enum {LOAD, SEARCH, DONE}.
  - Localparams for frame_id width, frame_index width and DW.
  - `popcount` function for reuse by other HDC blocks.
- Sub-module `hamming_popcount` (parameter W): XOR + popcount tree. It is combinational and instantiated once.
- Query buffer: NUM_FRAMES x W flop array; no reset is required on data.

## Test plan
- Load query = class 2 frames 0..2 exactly, with real `class_hvec_gen` attached → res_class=2, res_dist=0, and res_valid exactly 24 edges after the last load.
- Stub generator returning all-zeros for every class; query = three all-ones frames → tie across classes; res_class=0, res_dist=192 (full-width distance).
- Stub generator where class 5 equals the query and class 6 differs in 1 bit → res_class=5, res_dist=0. Then swap roles → res_class=6.
- Hold res_ready=0 for 10 cycles in DONE → res_valid, res_class and res_dist stay stable, q_ready=0. Query frames offered meanwhile are ignored.
- Assert rst_n low for one cycle at search cycle 12 → immediate q_ready=1, busy=0, res_valid=0. A fresh query afterwards gives the correct result.
- Query frames with q_valid gaps of 0, 1 and 3 cycles → buffer order is preserved; frame_index never equals 3 during SEARCH (assertion).

Source files
------------

// File: rtl/hdc_search_pkg.sv
// Shared types, widths and helpers for the HDC associative-memory search blocks.
package hdc_search_pkg;

    localparam int unsigned HDC_W_BITS      = 64;
    localparam int unsigned HDC_NUM_CLASSES = 8;
    localparam int unsigned HDC_NUM_FRAMES  = 3;
    localparam int unsigned HDC_FID_W       = $clog2(HDC_NUM_CLASSES);
    localparam int unsigned HDC_FIDX_W      = 2;
    localparam int unsigned HDC_DW          = $clog2(HDC_NUM_FRAMES * HDC_W_BITS + 1);
    localparam int unsigned HDC_PC_W        = $clog2(HDC_W_BITS + 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } search_state_t;

    // Population count of one frame-width vector.
    function automatic logic [HDC_PC_W-1:0] popcount(input logic [HDC_W_BITS-1:0] v);
        logic [HDC_PC_W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < HDC_W_BITS; i++) begin
            s = s + HDC_PC_W'(v[i]);
        end
        return s;
    endfunction

endpackage

// File: rtl/hamming_popcount.sv
// Combinational Hamming distance between two W-bit vectors (XOR then population count).
module hamming_popcount #(
    parameter int unsigned W = 64
) (
    input  logic [W-1:0]             vec_a,
    input  logic [W-1:0]             vec_b,
    output logic [$clog2(W+1)-1:0]   dist_c
);

    localparam int unsigned PC_W = $clog2(W + 1);

    logic [W-1:0] diff;

    assign diff = vec_a ^ vec_b;

    always_comb begin
        dist_c = '0;
        for (int unsigned i = 0; i < W; i++) begin
            dist_c = dist_c + PC_W'(diff[i]);
        end
    end

endmodule

// File: rtl/class_hvec_search.sv
// Nearest-class search: loads a query hypervector, walks every class frame by frame
// through the generator, and reports the class with the smallest Hamming distance.
module class_hvec_search
    import hdc_search_pkg::*;
#(
    parameter int unsigned DI_PARALLEL_W_BITS = HDC_W_BITS,
    parameter int unsigned NUM_CLASSES        = HDC_NUM_CLASSES,
    parameter int unsigned NUM_FRAMES         = HDC_NUM_FRAMES
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               q_valid,
    output logic                                               q_ready,
    input  logic [DI_PARALLEL_W_BITS-1:0]                      q_data,
    output logic [$clog2(NUM_CLASSES)-1:0]                     frame_id,
    output logic [1:0]                                         frame_index,
    input  logic [DI_PARALLEL_W_BITS-1:0]                      class_vec_in,
    output logic                                               res_valid,
    input  logic                                               res_ready,
    output logic [$clog2(NUM_CLASSES)-1:0]                     res_class,
    output logic [$clog2(NUM_FRAMES*DI_PARALLEL_W_BITS+1)-1:0] res_dist,
    output logic                                               busy
);

    localparam int unsigned FID_W  = $clog2(NUM_CLASSES);
    localparam int unsigned FIDX_W = 2;
    localparam int unsigned DW     = $clog2(NUM_FRAMES * DI_PARALLEL_W_BITS + 1);
    localparam int unsigned PC_W   = $clog2(DI_PARALLEL_W_BITS + 1);

    localparam logic [FIDX_W-1:0] LAST_FRM = FIDX_W'(NUM_FRAMES - 1);
    localparam logic [FID_W-1:0]  LAST_CLS = FID_W'(NUM_CLASSES - 1);

    search_state_t           state_q, state_d;
    logic [FIDX_W-1:0]       ld_cnt_q, ld_cnt_d;
    logic [FID_W-1:0]        cls_cnt_q, cls_cnt_d;
    logic [FIDX_W-1:0]       frm_cnt_q, frm_cnt_d;
    logic [DW-1:0]           acc_q, acc_d;
    logic [DW-1:0]           best_dist_q, best_dist_d;
    logic [FID_W-1:0]        best_class_q, best_class_d;
    logic [FID_W-1:0]        res_class_q, res_class_d;
    logic [DW-1:0]           res_dist_q, res_dist_d;
    logic                    q_ready_q, q_ready_d;
    logic                    res_valid_q, res_valid_d;
    logic                    busy_q, busy_d;
    logic [FID_W-1:0]        frame_id_q, frame_id_d;
    logic [FIDX_W-1:0]       frame_index_q, frame_index_d;
    logic [DI_PARALLEL_W_BITS-1:0] query_q [NUM_FRAMES];
    logic [DI_PARALLEL_W_BITS-1:0] query_d [NUM_FRAMES];

    logic                    q_acc_c;
    logic [PC_W-1:0]         pc_c;
    logic [DW-1:0]           total_c;
    logic                    better_c;
    logic [DW-1:0]           win_dist_c;
    logic [FID_W-1:0]        win_class_c;

    assign q_acc_c = q_valid && q_ready_q;

    hamming_popcount #(
        .W (DI_PARALLEL_W_BITS)
    ) u_hamming_popcount (
        .vec_a  (query_q[frm_cnt_q]),
        .vec_b  (class_vec_in),
        .dist_c (pc_c)
    );

    // Running class distance and the winner including this cycle's compare; strict < keeps the lower index on ties.
    assign total_c     = acc_q + DW'(pc_c);
    assign better_c    = total_c < best_dist_q;
    assign win_dist_c  = better_c ? total_c : best_dist_q;
    assign win_class_c = better_c ? cls_cnt_q : best_class_q;

    always_comb begin
        query_d = query_q;
        if (q_acc_c) begin
            query_d[ld_cnt_q] = q_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        ld_cnt_d     = ld_cnt_q;
        cls_cnt_d    = cls_cnt_q;
        frm_cnt_d    = frm_cnt_q;
        acc_d        = acc_q;
        best_dist_d  = best_dist_q;
        best_class_d = best_class_q;
        res_class_d  = res_class_q;
        res_dist_d   = res_dist_q;

        case (state_q)
            LOAD: begin
                if (q_acc_c) begin
                    if (ld_cnt_q == LAST_FRM) begin
                        ld_cnt_d     = '0;
                        cls_cnt_d    = '0;
                        frm_cnt_d    = '0;
                        acc_d        = '0;
                        best_dist_d  = '1;
                        best_class_d = '0;
                        state_d      = SEARCH;
                    end else begin
                        ld_cnt_d = ld_cnt_q + FIDX_W'(1);
                    end
                end
            end
            SEARCH: begin
                if (frm_cnt_q == LAST_FRM) begin
                    best_dist_d  = win_dist_c;
                    best_class_d = win_class_c;
                    acc_d        = '0;
                    frm_cnt_d    = '0;
                    cls_cnt_d    = cls_cnt_q + FID_W'(1);
                    if (cls_cnt_q == LAST_CLS) begin
                        res_class_d = win_class_c;
                        res_dist_d  = win_dist_c;
                        state_d     = DONE;
                    end
                end else begin
                    acc_d     = total_c;
                    frm_cnt_d = frm_cnt_q + FIDX_W'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        q_ready_d     = (state_d == LOAD);
        busy_d        = (state_d == SEARCH);
        res_valid_d   = (state_d == DONE);
        frame_id_d    = (state_d == SEARCH) ? cls_cnt_d : '0;
        frame_index_d = (state_d == SEARCH) ? frm_cnt_d : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= LOAD;
            ld_cnt_q      <= '0;
            cls_cnt_q     <= '0;
            frm_cnt_q     <= '0;
            acc_q         <= '0;
            best_dist_q   <= '1;
            best_class_q  <= '0;
            res_class_q   <= '0;
            res_dist_q    <= '0;
            q_ready_q     <= 1'b1;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            frame_id_q    <= '0;
            frame_index_q <= '0;
        end else begin
            state_q       <= state_d;
            ld_cnt_q      <= ld_cnt_d;
            cls_cnt_q     <= cls_cnt_d;
            frm_cnt_q     <= frm_cnt_d;
            acc_q         <= acc_d;
            best_dist_q   <= best_dist_d;
            best_class_q  <= best_class_d;
            res_class_q   <= res_class_d;
            res_dist_q    <= res_dist_d;
            q_ready_q     <= q_ready_d;
            res_valid_q   <= res_valid_d;
            busy_q        <= busy_d;
            frame_id_q    <= frame_id_d;
            frame_index_q <= frame_index_d;
        end
    end

    // Query payload needs no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        query_q <= query_d;
    end

    assign q_ready     = q_ready_q;
    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign res_class   = res_class_q;
    assign res_dist    = res_dist_q;
    assign frame_id    = frame_id_q;
    assign frame_index = frame_index_q;

endmodule

// File: tb/tb_class_hvec_search.sv
// Directed self-checking bench for class_hvec_search with a behavioural generator model.
module tb_class_hvec_search;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        q_valid = 1'b0;
    logic        q_ready;
    logic [63:0] q_data = '0;
    logic [2:0]  frame_id;
    logic [1:0]  frame_index;
    logic [63:0] class_vec_in;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [2:0]  res_class;
    logic [7:0]  res_dist;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    int          bad_fidx = 0;
    int          gen_mode = 0;
    logic [63:0] qv0 = '0;
    logic [63:0] qv1 = '0;
    logic [63:0] qv2 = '0;

    always #5 clk = ~clk;

    class_hvec_search dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .q_valid      (q_valid),
        .q_ready      (q_ready),
        .q_data       (q_data),
        .frame_id     (frame_id),
        .frame_index  (frame_index),
        .class_vec_in (class_vec_in),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_class    (res_class),
        .res_dist     (res_dist),
        .busy         (busy)
    );

    function automatic logic [63:0] rom(input int id, input int idx);
        logic [63:0] x;
        x = 64'h9E3779B97F4A7C15 * 64'(id * 3 + idx + 1);
        return x ^ (x >> 29);
    endfunction

    // Generator model: mode 0 pseudo-ROM, 1 all zeros, 2..4 stubs built around the query.
    function automatic logic [63:0] gen_vec(input int mode, input int id, input int fi_in,
                                            input logic [63:0] a0, input logic [63:0] a1,
                                            input logic [63:0] a2);
        logic [63:0] q;
        int          fi;
        fi = (fi_in > 2) ? 2 : fi_in;
        q  = (fi == 0) ? a0 : ((fi == 1) ? a1 : a2);
        case (mode)
            0: return rom(id, fi);
            1: return 64'h0;
            2: begin
                if (id == 5) return q;
                if (id == 6) return q ^ ((fi == 1) ? 64'h1 : 64'h0);
                return ~q;
            end
            3: begin
                if (id == 6) return q;
                if (id == 5) return q ^ ((fi == 1) ? 64'h1 : 64'h0);
                return ~q;
            end
            default: begin
                if (id == 1) return q ^ ((fi == 0) ? 64'h1F : 64'h0);
                if (id == 3) return q ^ ((fi == 0) ? 64'h1 : ((fi == 1) ? 64'h11 : 64'h8000_0000_0000_0004));
                return ~q;
            end
        endcase
    endfunction

    assign class_vec_in = gen_vec(gen_mode, int'(frame_id), int'(frame_index), qv0, qv1, qv2);

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && busy && frame_index == 2'd3) begin
            bad_fidx++;
            $display("FAIL fidx_range: frame_index=3 during search");
        end
    end

    task automatic load_query(input int g0, input int g1);
        logic [63:0] f [3];
        int          g [3];
        int          n;
        f[0] = qv0; f[1] = qv1; f[2] = qv2;
        g[0] = g0;  g[1] = g1;  g[2] = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            q_valid = 1'b1;
            q_data  = f[i];
            n = 0;
            while (!q_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("load_ready", q_ready, 1);
            @(posedge clk);
            #1;
            q_valid = 1'b0;
            q_data  = 64'hDEAD_BEEF_0BAD_F00D;
            repeat (g[i]) @(negedge clk);
        end
    endtask

    task automatic run_search(input logic [2:0] exp_cls, input logic [7:0] exp_dist, input int hold);
        int n;
        check("busy_after_load", busy, 1);
        check("q_ready_search", q_ready, 0);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!res_valid && n < 40);
        check("latency", n, 24);
        check("res_class", res_class, exp_cls);
        check("res_dist", res_dist, exp_dist);
        check("busy_done", busy, 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            q_valid = 1'b1;
            q_data  = ~qv0;
            @(posedge clk);
            #1;
            check("hold_valid", res_valid, 1);
            check("hold_class", res_class, exp_cls);
            check("hold_dist", res_dist, exp_dist);
            check("hold_q_ready", q_ready, 0);
        end
        @(negedge clk);
        q_valid   = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("res_valid_clear", res_valid, 0);
        check("q_ready_back", q_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_q_ready", q_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_class", res_class, 0);
        check("rst_res_dist", res_dist, 0);
        check("rst_frame_id", frame_id, 0);
        check("rst_frame_index", frame_index, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Query equals class 2 of the pseudo-ROM
        gen_mode = 0;
        qv0 = rom(2, 0); qv1 = rom(2, 1); qv2 = rom(2, 2);
        load_query(0, 0);
        run_search(3'd2, 8'd0, 0);

        // All classes at full distance: tie resolves to class 0
        gen_mode = 1;
        qv0 = '1; qv1 = '1; qv2 = '1;
        load_query(0, 0);
        run_search(3'd0, 8'd192, 0);

        // Class 5 exact, class 6 one bit off; also hold the result for 10 cycles
        gen_mode = 2;
        qv0 = 64'h0123_4567_89AB_CDEF; qv1 = 64'hF0F0_1234_5678_0F0F; qv2 = 64'hA5A5_5A5A_C3C3_3C3C;
        load_query(0, 0);
        run_search(3'd5, 8'd0, 10);

        // Roles swapped
        gen_mode = 3;
        load_query(0, 0);
        run_search(3'd6, 8'd0, 0);

        // Reset in the middle of a search
        gen_mode = 0;
        qv0 = rom(4, 0); qv1 = rom(4, 1); qv2 = rom(4, 2);
        load_query(0, 0);
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_q_ready", q_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_res_valid", res_valid, 0);
        check("midrst_frame_index", frame_index, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fresh query with gaps; classes 1 and 3 tie at 5, lower index wins
        gen_mode = 4;
        qv0 = 64'h1111_2222_3333_4444; qv1 = 64'h5555_6666_7777_8888; qv2 = 64'h9999_AAAA_BBBB_CCCC;
        load_query(1, 3);
        run_search(3'd1, 8'd5, 0);

        check("fidx_never3", bad_fidx, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
